register_pipe_vld_rdy: RTL

- Parametrised DEPTH-stage pipeline register with a valid/ready handshake, per-stage valid bits, bubble collapsing and synchronous flush.
- Successor of the single-stage enable register. Used to retime long datapaths between SVLib blocks without losing back-pressure.
- Stall freezes only the stages that cannot advance. Empty stages keep filling.

---
 rtl/svlib_pipe_pkg.sv | 15 +
 rtl/register_pipe_stage.sv | 40 ++++
 rtl/register_pipe_vld_rdy.sv | 126 ++++++++++++
 3 files changed

// File: rtl/svlib_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package     : svlib_pipe_pkg
// Description : Shared helpers for the SVLib valid/ready pipeline registers.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package svlib_pipe_pkg;

  // Width of an occupancy counter able to hold 0..depth+1 entries.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : register_pipe_stage
// Description : One slot of the valid/ready pipeline. Loads from its source
//               when allowed to advance; data only moves with a valid beat.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module register_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_dat,
  input  logic             adv,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  // Valid bit and payload; flush drops the valid bit but leaves data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= RESET_VAL;
    end else begin
      if (flush) begin
        vld <= 1'b0;
      end else if (adv) begin
        vld <= src_vld;
      end
      if (adv && src_vld && !flush) begin
        dat <= src_dat;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_pipe_vld_rdy.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : register_pipe_vld_rdy
// Description : DEPTH-stage valid/ready pipeline register with bubble
//               collapsing and synchronous flush. Optional one-entry skid
//               register in front of stage 0 when REGISTER_PIPE_SKID_EN is
//               defined (registered in_ready instead of a combinational chain).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module register_pipe_vld_rdy
  import svlib_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_dat [DEPTH];

  // Stage-0 source and skid contribution to occupancy.
  logic             s0_vld;
  logic [WIDTH-1:0] s0_dat;
  logic             skid_cnt;

  // Ready chain from the output backwards: a stage may load if the one ahead
  // moves or if it is itself empty (bubbles collapse).
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~vld[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~vld[i];
    end
  end

`ifdef REGISTER_PIPE_SKID_EN
  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;

  // Skid entry: catches a beat accepted while stage 0 is blocked, and is
  // released as soon as stage 0 can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld <= 1'b0;
      skid_dat <= RESET_VAL;
    end else if (flush) begin
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (adv[0]) begin
        skid_vld <= 1'b0;
      end
    end else if (in_valid && !adv[0]) begin
      skid_vld <= 1'b1;
      skid_dat <= in_data;
    end
  end

  assign s0_vld   = skid_vld | in_valid;
  assign s0_dat   = skid_vld ? skid_dat : in_data;
  assign in_ready = ~skid_vld;
  assign skid_cnt = skid_vld;
`else
  // Without a skid the input feeds stage 0 directly; a beat offered during
  // reset is accepted and dropped by the reset itself.
  assign s0_vld   = in_valid;
  assign s0_dat   = in_data;
  assign in_ready = adv[0] | rst;
  assign skid_cnt = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_vld[i] = s0_vld;
      assign src_dat[i] = s0_dat;
    end else begin : g_body
      assign src_vld[i] = vld[i-1];
      assign src_dat[i] = dat[i-1];
    end

    register_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .src_vld (src_vld[i]),
      .src_dat (src_dat[i]),
      .adv     (adv[i]),
      .vld     (vld[i]),
      .dat     (dat[i])
    );
  end

  // Occupancy is a popcount of the stage valid bits plus the skid entry.
  logic [OCC_W-1:0] occ_sum;
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(vld[i]);
    end
    occ_sum = occ_sum + OCC_W'(skid_cnt);
  end

  assign occupancy = occ_sum;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule
`default_nettype wire
